// File: rtl/nrs_ls_estimator.sv
// nrs_ls_estimator
// Least-squares channel estimator for NRS pilots. For each accepted pilot y it
// reads c(2m) and c(2m+1) from the NRS generator, forms the QPSK reference
// s = (1-2c0) + j(1-2c1) and produces h = y * conj(s) using only negation and
// addition. A running sum over the PILOTS pilots of a frame yields the frame
// average, emitted together with the estimate of the last pilot.

module nrs_ls_estimator #(
   parameter int WIDTH_REG = 16,
   parameter int LINES     = $clog2(WIDTH_REG),
   parameter int PILOTS    = WIDTH_REG / 2,
   parameter int IQ_W      = 16,
   parameter int H_W       = IQ_W + 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   new_frame,
   input  logic                   pilot_valid,
   input  logic signed [IQ_W-1:0] pilot_re,
   input  logic signed [IQ_W-1:0] pilot_im,
   output logic                   pilot_ready,
   output logic [LINES-1:0]       rd_addr_est,
   input  logic                   nrs_est,
   output logic                   h_valid,
   output logic signed [H_W-1:0]  h_re,
   output logic signed [H_W-1:0]  h_im,
   output logic                   avg_valid,
   output logic signed [H_W-1:0]  avg_re,
   output logic signed [H_W-1:0]  avg_im
);

   // log2(PILOTS): the average is a pure arithmetic shift
   localparam int SHIFT = $clog2(PILOTS);
   localparam int M_W   = (SHIFT > 0) ? SHIFT : 1;
   localparam int ACC_W = H_W + SHIFT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      MUL  = 2'd3
   } state_t;

   // Sign-extend x to H_W bits and optionally negate it (multiply by +/-1).
   // H_W leaves room so that negating the most negative input cannot wrap.
   function automatic logic signed [H_W-1:0] cond_neg(
      input logic signed [IQ_W-1:0] x,
      input logic                   neg
   );
      logic signed [H_W-1:0] ext;
      ext = {{(H_W-IQ_W){x[IQ_W-1]}}, x};
      if (neg) begin
         cond_neg = -ext;
      end else begin
         cond_neg = ext;
      end
   endfunction

   state_t                  state_q, state_d;
   logic [M_W-1:0]          m_q, m_d;
   logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
   logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
   logic signed [IQ_W-1:0]  yr_q, yr_d;
   logic signed [IQ_W-1:0]  yi_q, yi_d;
   logic                    c0_q, c0_d;
   logic                    h_valid_q, h_valid_d;
   logic signed [H_W-1:0]   h_re_q, h_re_d;
   logic signed [H_W-1:0]   h_im_q, h_im_d;
   logic                    avg_valid_q, avg_valid_d;
   logic signed [H_W-1:0]   avg_re_q, avg_re_d;
   logic signed [H_W-1:0]   avg_im_q, avg_im_d;

   logic                    ready_s;
   logic [LINES-1:0]        rd_addr_s;
   logic signed [H_W-1:0]   est_re_s, est_im_s;
   logic signed [ACC_W-1:0] sum_re_s, sum_im_s;
   logic signed [ACC_W-1:0] avg_re_full_s, avg_im_full_s;

   // Estimate datapath: a = 1-2*c0 (c0 registered), b = 1-2*c1 (c1 = nrs_est in MUL)
   //   h_re = yr*a + yi*b,  h_im = yi*a - yr*b
   // plus the accumulator update and the floor-rounded frame average.
   always_comb begin
      est_re_s      = cond_neg(yr_q, c0_q) + cond_neg(yi_q, nrs_est);
      est_im_s      = cond_neg(yi_q, c0_q) + cond_neg(yr_q, ~nrs_est);
      sum_re_s      = acc_re_q + ACC_W'(est_re_s);
      sum_im_s      = acc_im_q + ACC_W'(est_im_s);
      avg_re_full_s = sum_re_s >>> SHIFT;
      avg_im_full_s = sum_im_s >>> SHIFT;
   end

   // Next-state and control: new_frame overrides the sequence and aborts any
   // pilot in flight; otherwise walk IDLE -> RD0 -> RD1 -> MUL -> IDLE.
   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      yr_d        = yr_q;
      yi_d        = yi_q;
      c0_d        = c0_q;
      h_valid_d   = 1'b0;
      h_re_d      = h_re_q;
      h_im_d      = h_im_q;
      avg_valid_d = 1'b0;
      avg_re_d    = avg_re_q;
      avg_im_d    = avg_im_q;
      ready_s     = 1'b0;
      rd_addr_s   = {LINES{1'b0}};

      if (new_frame) begin
         state_d  = IDLE;
         m_d      = {M_W{1'b0}};
         acc_re_d = {ACC_W{1'b0}};
         acc_im_d = {ACC_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               ready_s = 1'b1;
               if (pilot_valid) begin
                  yr_d    = pilot_re;
                  yi_d    = pilot_im;
                  state_d = RD0;
               end else begin
                  state_d = IDLE;
               end
            end
            RD0: begin
               rd_addr_s = LINES'({m_q, 1'b0});
               state_d   = RD1;
            end
            RD1: begin
               // nrs_est now carries c(2m), requested during RD0
               rd_addr_s = LINES'({m_q, 1'b1});
               c0_d      = nrs_est;
               state_d   = MUL;
            end
            MUL: begin
               h_valid_d = 1'b1;
               h_re_d    = est_re_s;
               h_im_d    = est_im_s;
               state_d   = IDLE;
               if (m_q == M_W'(PILOTS - 1)) begin
                  avg_valid_d = 1'b1;
                  avg_re_d    = avg_re_full_s[H_W-1:0];
                  avg_im_d    = avg_im_full_s[H_W-1:0];
                  m_d         = {M_W{1'b0}};
                  acc_re_d    = {ACC_W{1'b0}};
                  acc_im_d    = {ACC_W{1'b0}};
               end else begin
                  m_d      = m_q + M_W'(1);
                  acc_re_d = sum_re_s;
                  acc_im_d = sum_im_s;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         m_q         <= {M_W{1'b0}};
         acc_re_q    <= {ACC_W{1'b0}};
         acc_im_q    <= {ACC_W{1'b0}};
         yr_q        <= {IQ_W{1'b0}};
         yi_q        <= {IQ_W{1'b0}};
         c0_q        <= 1'b0;
         h_valid_q   <= 1'b0;
         h_re_q      <= {H_W{1'b0}};
         h_im_q      <= {H_W{1'b0}};
         avg_valid_q <= 1'b0;
         avg_re_q    <= {H_W{1'b0}};
         avg_im_q    <= {H_W{1'b0}};
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         yr_q        <= yr_d;
         yi_q        <= yi_d;
         c0_q        <= c0_d;
         h_valid_q   <= h_valid_d;
         h_re_q      <= h_re_d;
         h_im_q      <= h_im_d;
         avg_valid_q <= avg_valid_d;
         avg_re_q    <= avg_re_d;
         avg_im_q    <= avg_im_d;
      end
   end

   // Output stage: every output reads 0 while rst is high, including the
   // rst cycle itself, otherwise the registered values are presented.
   always_comb begin
      if (rst) begin
         pilot_ready = 1'b0;
         rd_addr_est = {LINES{1'b0}};
         h_valid     = 1'b0;
         h_re        = {H_W{1'b0}};
         h_im        = {H_W{1'b0}};
         avg_valid   = 1'b0;
         avg_re      = {H_W{1'b0}};
         avg_im      = {H_W{1'b0}};
      end else begin
         pilot_ready = ready_s;
         rd_addr_est = rd_addr_s;
         h_valid     = h_valid_q;
         h_re        = h_re_q;
         h_im        = h_im_q;
         avg_valid   = avg_valid_q;
         avg_re      = avg_re_q;
         avg_im      = avg_im_q;
      end
   end

endmodule
